// File: rtl/main_fsm_if.sv
// Control bus between the multicycle main FSM and the shared-ALU /
// shared-memory RISC-V datapath. The FSM is the master: it receives the
// opcode from the instruction register and drives every control line.
interface main_fsm_if;
    logic [6:0] opcode;
    logic       PCUpdate;
    logic       Branch;
    logic       RegWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode,
        output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
    );

    modport slave (
        output opcode,
        input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle main control FSM for the RISC-V datapath.
// Sequences lw, sw, R-type, I-type ALU, beq and jal through fetch, decode,
// execute, memory and writeback states, with WAIT_STATES extra cycles on
// every memory access (instruction fetch, load, store).
// Optional build macro ILLEGAL_TRAP_EN: when defined, an unrecognised opcode
// parks the machine in HALT and raises the sticky illegal flag; when
// undefined, unrecognised opcodes retire as a nop from DECODE.
module main_fsm #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    main_fsm_if.master bus
);

    localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_STATES);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL,
        HALT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last_wait;

    logic          is_lw;
    logic          is_sw;
    logic          is_r;
    logic          is_i;
    logic          is_beq;
    logic          is_jal;
    logic          known_op;
    logic [1:0]    imm_src;

    logic          pc_update;
    logic          branch;
    logic          reg_write;
    logic          mem_write;
    logic          ir_write;
    logic          adr_src;
    logic [1:0]    result_src;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op;
    logic          instr_done;

    // The wait counter sits at WAIT_STATES on the final cycle of a memory access.
    assign last_wait = (cnt_q == LAST_CNT);

    // Opcode classification and immediate-format select, straight from the IR.
    always_comb begin
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_beq  = 1'b0;
        is_jal  = 1'b0;
        imm_src = 2'b00;
        case (bus.opcode)
            OP_LW:  begin is_lw  = 1'b1; imm_src = 2'b00; end
            OP_SW:  begin is_sw  = 1'b1; imm_src = 2'b01; end
            OP_R:   begin is_r   = 1'b1; imm_src = 2'b00; end
            OP_I:   begin is_i   = 1'b1; imm_src = 2'b00; end
            OP_BEQ: begin is_beq = 1'b1; imm_src = 2'b10; end
            OP_JAL: begin is_jal = 1'b1; imm_src = 2'b11; end
            default: imm_src = 2'b00;
        endcase
    end

    assign known_op = is_lw | is_sw | is_r | is_i | is_beq | is_jal;

    // State register and wait counter; reset always lands in FETCH with the counter clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter only advances while a memory access is still waiting.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            FETCH: begin
                if (last_wait) begin
                    state_d = DECODE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DECODE: begin
                if (is_lw || is_sw) begin
                    state_d = MEMADR;
                end else if (is_r) begin
                    state_d = EXECUTER;
                end else if (is_i) begin
                    state_d = EXECUTEI;
                end else if (is_beq) begin
                    state_d = BEQ;
                end else if (is_jal) begin
                    state_d = JAL;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = FETCH;
`endif
                end
            end
            MEMADR: begin
                state_d = is_sw ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                if (last_wait) begin
                    state_d = MEMWB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MEMWB: begin
                state_d = FETCH;
            end
            MEMWRITE: begin
                if (last_wait) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EXECUTER: begin
                state_d = ALUWB;
            end
            EXECUTEI: begin
                state_d = ALUWB;
            end
            ALUWB: begin
                state_d = FETCH;
            end
            BEQ: begin
                state_d = FETCH;
            end
            JAL: begin
                state_d = ALUWB;
            end
            HALT: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = HALT;
`else
                state_d = FETCH;
`endif
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Moore control decode from state and wait counter; the nop retire in DECODE is the one opcode-qualified output.
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                adr_src    = 1'b0;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b10;
                if (last_wait) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
`ifndef ILLEGAL_TRAP_EN
                instr_done = ~known_op;
`endif
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = 2'b00;
                mem_write  = 1'b1;
                instr_done = last_wait;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = 2'b01;
                result_src = 2'b00;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b00;
                pc_update  = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag: raised on the edge that enters HALT, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_d == HALT) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.PCUpdate   = pc_update;
    assign bus.Branch     = branch;
    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUOp      = alu_op;
    assign bus.ImmSrc     = imm_src;
    assign bus.instr_done = instr_done;

endmodule
